// File: rtl/sram_arb_pkg.sv
// Shared types and bus widths for the SRAM port arbiter.
// Build option SRAM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
package sram_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_INST = 2'd1,
        WIN_DATA = 2'd2
    } win_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One requester port of the SRAM arbiter: same-cycle req/gnt, response one cycle after grant.
interface sram_port_arbiter_if;
    import sram_arb_pkg::*;

    logic              req;
    logic [BE_W-1:0]   wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wen, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wen, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sram_arb_pick.sv
// Pure winner selection between the fetch and memory ports.
// SRAM_ARB_RR_EN: alternate on contention using last_win; otherwise data first, wait_cnt forces inst.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
    output win_t             win,
    input  logic             inst_req,
`ifdef SRAM_ARB_RR_EN
    input  logic             last_win,
`else
    input  logic [CNT_W-1:0] wait_cnt,
`endif
    input  logic             data_req
);

    logic w_inst_first;

`ifdef SRAM_ARB_RR_EN
    assign w_inst_first = !last_win;
`else
    assign w_inst_first = (wait_cnt == CNT_W'(MAX_WAIT));
`endif

    always_comb begin
        win = WIN_NONE;
        if (inst_req && data_req) begin
            win = w_inst_first ? WIN_INST : WIN_DATA;
        end else if (inst_req) begin
            win = WIN_INST;
        end else if (data_req) begin
            win = WIN_DATA;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported 1-cycle-latency SRAM between the fetch and memory stages.
// SRAM_ARB_RR_EN defined: round-robin; undefined: data priority with inst starvation guard.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    sram_port_arbiter_if.slave inst_port,
    sram_port_arbiter_if.slave data_port,
    output logic              sram_en,
    output logic [BE_W-1:0]   sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic w_inst_req;
    logic w_data_req;
    logic w_inst_gnt;
    logic w_data_gnt;
    win_t w_win;
    logic r_pend_inst;
    logic r_pend_data;

    // Reset masks requests so no grant escapes while it is held.
    assign w_inst_req = inst_port.req & ~reset;
    assign w_data_req = data_port.req & ~reset;

`ifdef SRAM_ARB_RR_EN
    logic r_last_win;

    sram_arb_pick u_pick (
        .win      (w_win),
        .inst_req (w_inst_req),
        .last_win (r_last_win),
        .data_req (w_data_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_win <= 1'b0;
        end else if (w_inst_gnt) begin
            r_last_win <= 1'b1;
        end else if (w_data_gnt) begin
            r_last_win <= 1'b0;
        end
    end
`else
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    sram_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_pick (
        .win      (w_win),
        .inst_req (w_inst_req),
        .wait_cnt (r_wait_cnt),
        .data_req (w_data_req)
    );

    // Counts consecutive denied fetch cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (reset || !w_inst_req || w_inst_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end
`endif

    assign w_inst_gnt = (w_win == WIN_INST);
    assign w_data_gnt = (w_win == WIN_DATA);

    // Drive the SRAM with the winner's request; all zero when idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (w_win)
            WIN_INST: begin
                sram_en    = 1'b1;
                sram_wen   = inst_port.wen;
                sram_addr  = inst_port.addr;
                sram_wdata = inst_port.wdata;
            end
            WIN_DATA: begin
                sram_en    = 1'b1;
                sram_wen   = data_port.wen;
                sram_addr  = data_port.addr;
                sram_wdata = data_port.wdata;
            end
            default: begin
                sram_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_inst <= 1'b0;
            r_pend_data <= 1'b0;
        end else begin
            r_pend_inst <= w_inst_gnt;
            r_pend_data <= w_data_gnt;
        end
    end

    assign inst_port.gnt    = w_inst_gnt;
    assign data_port.gnt    = w_data_gnt;
    assign inst_port.rvalid = r_pend_inst;
    assign data_port.rvalid = r_pend_data;
    assign inst_port.rdata  = r_pend_inst ? sram_rdata : '0;
    assign data_port.rdata  = r_pend_data ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed-vector bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
// Honours SRAM_ARB_RR_EN for the contention sequences.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int P_NONE = 0;
    localparam int P_INST = 1;
    localparam int P_DATA = 2;

    typedef struct {
        logic        rst;
        logic        chk_rv;
        logic        i_req;
        logic [3:0]  i_wen;
        logic [31:0] i_addr;
        logic [31:0] i_wdata;
        logic        d_req;
        logic [3:0]  d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_igt;
        logic        e_dgt;
        logic [3:0]  e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter_if inst_if ();
    sram_port_arbiter_if data_if ();

    sram_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_port  (inst_if),
        .data_port  (data_if),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Behavioural SRAM: reads return a pattern of the address, writes return zero.
    always @(posedge clk) begin
        sram_rdata <= (sram_en && sram_wen == '0) ? rd_pat(sram_addr) : '0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // A request pending without grant must still be present next cycle.
    logic pend_i = 1'b0;
    logic pend_d = 1'b0;
    always @(negedge clk) begin
        if (!reset && pend_i) chk("withdraw_inst", 32'(inst_if.req), 32'd1);
        if (!reset && pend_d) chk("withdraw_data", 32'(data_if.req), 32'd1);
        pend_i = !reset && inst_if.req && !inst_if.gnt;
        pend_d = !reset && data_if.req && !data_if.gnt;
    end

    function automatic vec_t mk(
        input logic ir, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] iwd,
        input logic dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd,
        input logic eig, input logic edg, input logic [3:0] ewen, input logic [31:0] ea,
        input logic [31:0] ewd, input logic eirv, input logic edrv,
        input logic [31:0] eird, input logic [31:0] edrd);
        vec_t v;
        v.rst = 1'b0;   v.chk_rv = 1'b1;
        v.i_req = ir;   v.i_wen = iw;   v.i_addr = ia;  v.i_wdata = iwd;
        v.d_req = dr;   v.d_wen = dw;   v.d_addr = da;  v.d_wdata = dwd;
        v.e_igt = eig;  v.e_dgt = edg;  v.e_wen = ewen; v.e_addr = ea; v.e_wdata = ewd;
        v.e_irv = eirv; v.e_drv = edrv; v.e_ird = eird; v.e_drd = edrd;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        reset         = v.rst;
        inst_if.req   = v.i_req;
        inst_if.wen   = v.i_wen;
        inst_if.addr  = v.i_addr;
        inst_if.wdata = v.i_wdata;
        data_if.req   = v.d_req;
        data_if.wen   = v.d_wen;
        data_if.addr  = v.d_addr;
        data_if.wdata = v.d_wdata;
        @(negedge clk);
        chk({tag, " inst_gnt"},   32'(inst_if.gnt), 32'(v.e_igt));
        chk({tag, " data_gnt"},   32'(data_if.gnt), 32'(v.e_dgt));
        chk({tag, " sram_en"},    32'(sram_en),     32'(v.e_igt | v.e_dgt));
        chk({tag, " sram_wen"},   32'(sram_wen),    32'(v.e_wen));
        chk({tag, " sram_addr"},  sram_addr,        v.e_addr);
        chk({tag, " sram_wdata"}, sram_wdata,       v.e_wdata);
        if (v.chk_rv) begin
            chk({tag, " inst_rvalid"}, 32'(inst_if.rvalid), 32'(v.e_irv));
            chk({tag, " data_rvalid"}, 32'(data_if.rvalid), 32'(v.e_drv));
            chk({tag, " inst_rdata"},  inst_if.rdata,       v.e_ird);
            chk({tag, " data_rdata"},  data_if.rdata,       v.e_drd);
        end
    endtask

    vec_t tbl [12];
    vec_t v;
    int   win;
    int   prev;
    int   drain;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] prev_addr;

    initial begin
        inst_if.req = 1'b0; inst_if.wen = '0; inst_if.addr = '0; inst_if.wdata = '0;
        data_if.req = 1'b0; data_if.wen = '0; data_if.addr = '0; data_if.wdata = '0;

        // Single-requester and priority vectors, applied one per cycle.
        tbl[0]  = mk(0, 0, 0, 0,                 0, 0, 0, 0,                      0, 0, 0, 0, 0,                      0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 'h1000, 0,            0, 0, 0, 0,                      1, 0, 0, 'h1000, 0,                 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0,                 0, 0, 0, 0,                      0, 0, 0, 0, 0,                      1, 0, rd_pat('h1000), 0);
        tbl[3]  = mk(0, 0, 0, 0,                 1, 0, 'h2000, 0,                 0, 1, 0, 'h2000, 0,                 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,                 1, 0, 'h2004, 0,                 0, 1, 0, 'h2004, 0,                 0, 1, 0, rd_pat('h2000));
        tbl[5]  = mk(1, 0, 'h1004, 0,            0, 0, 0, 0,                      1, 0, 0, 'h1004, 0,                 0, 1, 0, rd_pat('h2004));
        tbl[6]  = mk(1, 0, 'h1008, 0,            1, 4'b0011, 'h3000, 'hDEADBEEF,  0, 1, 4'b0011, 'h3000, 'hDEADBEEF,  1, 0, rd_pat('h1004), 0);
        tbl[7]  = mk(1, 0, 'h1008, 0,            0, 0, 0, 0,                      1, 0, 0, 'h1008, 0,                 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,                 0, 0, 0, 0,                      0, 0, 0, 0, 0,                      1, 0, rd_pat('h1008), 0);
        tbl[9]  = mk(1, 4'hF, 'h1100, 'h12345678, 0, 0, 0, 0,                     1, 0, 4'hF, 'h1100, 'h12345678,    0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,                 0, 0, 0, 0,                      0, 0, 0, 0, 0,                      1, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,                 0, 0, 0, 0,                      0, 0, 0, 0, 0,                      0, 0, 0, 0);

        // Reset state: no grant or SRAM activity even with both ports requesting.
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rst = 1'b1; v.chk_rv = 1'b0;
        apply(v, "rst0");
        v.i_req = 1'b1; v.i_addr = 'h0040; v.d_req = 1'b1; v.d_wen = 4'hF; v.d_addr = 'h0080;
        apply(v, "rst1");

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Grant an inst read, then reset: the response must be dropped.
        v = mk(1, 0, 'h5000, 0, 0, 0, 0, 0, 1, 0, 0, 'h5000, 0, 0, 0, 0, 0);
        apply(v, "pre_rst_gnt");
        v = mk(1, 0, 'h7000, 0, 1, 4'hF, 'h8000, 'h0BAD_F00D, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rst = 1'b1; v.chk_rv = 1'b0;
        apply(v, "in_rst");

        // Continuous contention from the first cycle after reset.
        ia = 'h7000; da = 'h8000; prev = P_NONE; prev_addr = '0; win = P_NONE;
        for (int k = 0; k < 10; k++) begin
            if (RR) win = (k % 2 == 0) ? P_INST : P_DATA;
            else    win = (k % 5 == 4) ? P_INST : P_DATA;
            v = mk(1, 0, ia, 0, 1, 0, da, 0,
                   win == P_INST, win == P_DATA, 0, (win == P_INST) ? ia : da, 0,
                   prev == P_INST, prev == P_DATA,
                   (prev == P_INST) ? rd_pat(prev_addr) : 32'h0,
                   (prev == P_DATA) ? rd_pat(prev_addr) : 32'h0);
            apply(v, $sformatf("cont%0d", k));
            prev      = win;
            prev_addr = (win == P_INST) ? ia : da;
            if (win == P_INST) ia = ia + 32'd4;
            else               da = da + 32'd4;
        end

        // The port denied last keeps its request alone until granted.
        drain = (prev == P_INST) ? P_DATA : P_INST;
        v = mk(drain == P_INST, 0, ia, 0, drain == P_DATA, 0, da, 0,
               drain == P_INST, drain == P_DATA, 0, (drain == P_INST) ? ia : da, 0,
               prev == P_INST, prev == P_DATA,
               (prev == P_INST) ? rd_pat(prev_addr) : 32'h0,
               (prev == P_DATA) ? rd_pat(prev_addr) : 32'h0);
        apply(v, "drain");
        prev_addr = (drain == P_INST) ? ia : da;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               drain == P_INST, drain == P_DATA,
               (drain == P_INST) ? rd_pat(prev_addr) : 32'h0,
               (drain == P_DATA) ? rd_pat(prev_addr) : 32'h0);
        apply(v, "drain_rsp");

        // Ten idle cycles: everything quiet.
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            apply(v, $sformatf("idle%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
